// File: rtl/axistream_forwarder.sv
// rtl/axistream_forwarder.sv - claims forwarder packets, reads packet memory, emits AXI-Stream
// Optional FWD_STATS_EN adds pkt_count/byte_count outputs.
module axistream_forwarder #(
    parameter int PACKET_MEM_BYTES   = 2048,
    parameter int PACKMEM_DATA_WIDTH = 64,
    parameter int PLEN_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 4,
    localparam int BPW               = PACKMEM_DATA_WIDTH / 8,
    localparam int PACKMEM_ADDR_WIDTH = $clog2(PACKET_MEM_BYTES) - $clog2(BPW)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy_for_fwd,
    output logic                          rdy_for_fwd_ack,
    input  logic [PLEN_WIDTH-1:0]         fwd_byte_len,
    output logic [PACKMEM_ADDR_WIDTH-1:0] fwd_addr,
    output logic                          fwd_rd_en,
    input  logic [PACKMEM_DATA_WIDTH-1:0] fwd_rd_data,
    input  logic                          fwd_rd_data_vld,
    output logic                          fwd_done,
    output logic [PACKMEM_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [BPW-1:0]                m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                   pkt_count,
    output logic [31:0]                   byte_count
`endif
);

    localparam int BPW_LOG = $clog2(BPW);
    localparam int LW      = $clog2(PACKET_MEM_BYTES) + 1;
    localparam int CW      = PACKMEM_ADDR_WIDTH + 1;
    localparam int FAW     = $clog2(FIFO_DEPTH);
    localparam int FCW     = FAW + 1;

    typedef enum logic [2:0] {IDLE, ACK, LEN, READ, DRAIN, DONE} state_t;
    state_t state;

    logic [LW-1:0]  len_q;
    logic [CW-1:0]  nwords, issue_cnt, rx_cnt, pop_cnt;
    logic [FCW-1:0] outstanding, fifo_count;
    logic [FAW-1:0] wr_ptr, rd_ptr;

    logic [PACKMEM_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [BPW-1:0]                mem_keep [FIFO_DEPTH];
    logic                          mem_last [FIFO_DEPTH];

    logic [LW-1:0]  len_clamped;
    logic [CW-1:0]  nwords_next;
    logic [FCW:0]   credit_used;
    logic [BPW_LOG-1:0] len_rem;
    logic [BPW-1:0] keep_final, push_keep;
    logic           issue, push, pop, push_last;

    always_comb begin
        len_clamped = (fwd_byte_len > PLEN_WIDTH'(PACKET_MEM_BYTES)) ? LW'(PACKET_MEM_BYTES)
                                                                     : fwd_byte_len[LW-1:0];
        nwords_next = CW'((len_clamped + LW'(BPW - 1)) >> BPW_LOG);
        credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
        issue       = (state == READ) && (credit_used < (FCW+1)'(FIFO_DEPTH));
        // Read data is only meaningful while this packet is in flight.
        push        = fwd_rd_data_vld && ((state == READ) || (state == DRAIN));
        pop         = (fifo_count != '0) && m_axis_tready;
        len_rem     = len_q[BPW_LOG-1:0];
        keep_final  = (len_rem == '0) ? {BPW{1'b1}} : ~({BPW{1'b1}} >> len_rem);
        push_last   = (rx_cnt == nwords - CW'(1));
        push_keep   = push_last ? keep_final : {BPW{1'b1}};
    end

    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr] : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? mem_keep[rd_ptr] : '0;
    assign m_axis_tlast  = m_axis_tvalid & mem_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= fwd_rd_data;
            mem_keep[wr_ptr] <= push_keep;
            mem_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rdy_for_fwd_ack <= 1'b0;
            fwd_done        <= 1'b0;
            fwd_rd_en       <= 1'b0;
            fwd_addr        <= '0;
            len_q           <= '0;
            nwords          <= '0;
            issue_cnt       <= '0;
            rx_cnt          <= '0;
            pop_cnt         <= '0;
            outstanding     <= '0;
            fifo_count      <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
`ifdef FWD_STATS_EN
            pkt_count       <= '0;
            byte_count      <= '0;
`endif
        end else begin
            rdy_for_fwd_ack <= 1'b0;
            fwd_done        <= 1'b0;
            fwd_rd_en       <= 1'b0;

            case (state)
                IDLE: begin
                    if (rdy_for_fwd) begin
                        rdy_for_fwd_ack <= 1'b1;
                        state           <= ACK;
                    end
                end
                ACK: state <= LEN;
                LEN: begin
                    len_q     <= len_clamped;
                    nwords    <= nwords_next;
                    issue_cnt <= '0;
                    rx_cnt    <= '0;
                    pop_cnt   <= '0;
                    if (len_clamped == '0) begin
                        fwd_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state    <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        fwd_rd_en <= 1'b1;
                        fwd_addr  <= issue_cnt[PACKMEM_ADDR_WIDTH-1:0];
                        issue_cnt <= issue_cnt + CW'(1);
                        if (issue_cnt == nwords - CW'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_cnt == nwords) begin
                        fwd_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef FWD_STATS_EN
                    pkt_count  <= pkt_count + 32'd1;
                    byte_count <= byte_count + 32'(len_q);
`endif
                end
                default: state <= IDLE;
            endcase

            // Credits are taken at issue time, so the FIFO always has room for returning data.
            outstanding <= outstanding + FCW'(issue) - FCW'(push);
            fifo_count  <= fifo_count + FCW'(push) - FCW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + FAW'(1);
                rx_cnt <= rx_cnt + CW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + FAW'(1);
                pop_cnt <= pop_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axistream_forwarder.sv
// tb/tb_axistream_forwarder.sv - directed bench for axistream_forwarder
// Memory responder has a fixed 3-cycle read latency; AXIS is sampled on the falling edge.
module tb_axistream_forwarder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_for_fwd;
    logic        rdy_for_fwd_ack;
    logic [31:0] fwd_byte_len;
    logic [7:0]  fwd_addr;
    logic        fwd_rd_en;
    logic [63:0] fwd_rd_data = '0;
    logic        fwd_rd_data_vld = 1'b0;
    logic        fwd_done;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
`ifdef FWD_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] byte_count;
`endif

    always #5 clk = ~clk;

    axistream_forwarder dut (
        .clk             (clk),
        .rst             (rst),
        .rdy_for_fwd     (rdy_for_fwd),
        .rdy_for_fwd_ack (rdy_for_fwd_ack),
        .fwd_byte_len    (fwd_byte_len),
        .fwd_addr        (fwd_addr),
        .fwd_rd_en       (fwd_rd_en),
        .fwd_rd_data     (fwd_rd_data),
        .fwd_rd_data_vld (fwd_rd_data_vld),
        .fwd_done        (fwd_done),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready)
`ifdef FWD_STATS_EN
        ,
        .pkt_count       (pkt_count),
        .byte_count      (byte_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_val(input int a);
        return 64'hC0DE_0000_0000_0000 ^ (64'(a) * 64'h0001_0003_0007_000B);
    endfunction

    function automatic logic [7:0] last_keep(input int r);
        case (r)
            1: return 8'h80;
            2: return 8'hC0;
            3: return 8'hE0;
            4: return 8'hF0;
            5: return 8'hF8;
            6: return 8'hFC;
            7: return 8'hFE;
            default: return 8'hFF;
        endcase
    endfunction

    int cyc = 0, acks, dones, issued, beats, max_inflight, ack_cyc, done_cyc;
    bit tvalid_seen, stall_en = 0, stall_req = 0;
    int stall_left = 0;
    logic [63:0] q_data [$];
    logic [7:0]  q_keep [$];
    logic        q_last [$];
    int          q_addr [$];
    logic        pv0 = 0, pv1 = 0;
    logic [63:0] pd0 = '0, pd1 = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pv0 = 0; pv1 = 0; fwd_rd_data_vld = 0;
        end else begin
            fwd_rd_data_vld = pv1; fwd_rd_data = pd1;
            pv1 = pv0; pd1 = pd0;
            pv0 = fwd_rd_en; pd0 = word_val(int'(fwd_addr));
        end
        if (stall_req) begin
            m_axis_tready = 0; stall_left = 20; stall_req = 0;
        end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) m_axis_tready = 1;
        end
        if (fwd_rd_en) begin issued++; q_addr.push_back(int'(fwd_addr)); end
        if (rdy_for_fwd_ack) begin acks++; ack_cyc = cyc; end
        if (fwd_done) begin dones++; done_cyc = cyc; end
        if (m_axis_tvalid) tvalid_seen = 1;
        if (m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_keep.push_back(m_axis_tkeep);
            q_last.push_back(m_axis_tlast);
            beats++;
            if (stall_en && beats == 2) stall_req = 1;
        end
        if (issued - beats > max_inflight) max_inflight = issued - beats;
    end

    task automatic clear_mon();
        acks = 0; dones = 0; issued = 0; beats = 0; max_inflight = 0;
        ack_cyc = 0; done_cyc = 0; tvalid_seen = 0;
        q_data.delete(); q_keep.delete(); q_last.delete(); q_addr.delete();
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic claim(input int len);
        int n;
        step();
        clear_mon();
        fwd_byte_len = len;
        rdy_for_fwd  = 1;
        n = 0;
        while (acks == 0 && n < 50) begin step(); n++; end
        chk("ack_timeout", 64'(acks != 0), 64'd1);
        rdy_for_fwd = 0;
    endtask

    task automatic run_pkt(input int len);
        int n;
        claim(len);
        n = 0;
        while (dones == 0 && n < 3000) begin step(); n++; end
        chk("done_timeout", 64'(dones != 0), 64'd1);
        repeat (3) step();
    endtask

    task automatic verify(input string name, input int len);
        int lc, nw;
        lc = (len > 2048) ? 2048 : len;
        nw = (lc + 7) / 8;
        chk({name, "_acks"}, 64'(acks), 64'd1);
        chk({name, "_dones"}, 64'(dones), 64'd1);
        chk({name, "_beats"}, 64'(beats), 64'(nw));
        chk({name, "_issued"}, 64'(issued), 64'(nw));
        foreach (q_data[i]) begin
            chk($sformatf("%s_data%0d", name, i), q_data[i], word_val(i));
            chk($sformatf("%s_keep%0d", name, i), 64'(q_keep[i]),
                64'((i == nw - 1) ? last_keep(lc % 8) : 8'hFF));
            chk($sformatf("%s_last%0d", name, i), 64'(q_last[i]), 64'(i == nw - 1));
        end
        foreach (q_addr[i])
            chk($sformatf("%s_addr%0d", name, i), 64'(q_addr[i]), 64'(i));
    endtask

    initial begin
        int n;
        rst = 1; rdy_for_fwd = 0; fwd_byte_len = '0;
        repeat (3) step();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_ack", 64'(rdy_for_fwd_ack), 64'd0);
        chk("rst_done", 64'(fwd_done), 64'd0);
        chk("rst_rd_en", 64'(fwd_rd_en), 64'd0);
        chk("rst_tkeep_tlast", {55'd0, m_axis_tlast, m_axis_tkeep}, 64'd0);
        rst = 0;

        run_pkt(64);
        verify("l64", 64);
        chk("l64_keep_last", 64'(q_keep[7]), 64'hFF);

        run_pkt(13);
        verify("l13", 13);
        chk("l13_keep1", 64'(q_keep[1]), 64'hF8);

        stall_en = 1;
        run_pkt(64);
        verify("stall", 64);
        chk("stall_inflight", 64'(max_inflight), 64'd4);
        stall_en = 0;
        n = 0;
        while (stall_left != 0 && n < 40) begin step(); n++; end

        run_pkt(0);
        chk("l0_acks", 64'(acks), 64'd1);
        chk("l0_dones", 64'(dones), 64'd1);
        chk("l0_ack_to_done", 64'(done_cyc - ack_cyc), 64'd2);
        chk("l0_tvalid", 64'(tvalid_seen), 64'd0);

        run_pkt(3000);
        verify("clamp", 3000);

        claim(64);
        n = 0;
        while (beats < 3 && n < 100) begin step(); n++; end
        chk("rstmid_beat_timeout", 64'(beats >= 3), 64'd1);
        rst = 1;
        step();
        chk("rstmid_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rstmid_tdata", m_axis_tdata, 64'd0);
        chk("rstmid_rd_en", 64'(fwd_rd_en), 64'd0);
        chk("rstmid_done_out", 64'(fwd_done), 64'd0);
        rst = 0;
        repeat (10) step();
        chk("rstmid_no_done", 64'(dones), 64'd0);

        run_pkt(13);
        verify("post_rst", 13);

`ifdef FWD_STATS_EN
        run_pkt(64);
        run_pkt(1);
        verify("l1", 1);
        chk("stats_pkts", 64'(pkt_count), 64'd3);
        chk("stats_bytes", 64'(byte_count), 64'd78);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
